// File: rtl/branch_resolve.sv
// EX-stage branch resolution: carries IF prediction bits to EX, resolves branches/JALR,
// drives the predictor update bus and the fetch redirect. BRANCH_PERF_CNT_EN adds perf counters.
module branch_resolve #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] pc_if,
  input  logic                  predict_taken_if,
  input  logic                  predict0_taken_if,
  input  logic                  predict1_taken_if,
  input  logic                  predict3_taken_if,
  input  logic [ADDR_WIDTH-1:0] predict_target_pc_if,
  input  logic                  stall_dec,
  input  logic                  branch_dec,
  input  logic                  jalr_dec,
  input  logic                  is_loop_dec,
  input  logic [2:0]            funct3_dec,
  input  logic [ADDR_WIDTH-1:0] imm_dec,
  input  logic [DATA_WIDTH-1:0] src_data1_ex,
  input  logic [DATA_WIDTH-1:0] src_data2_ex,
  input  logic                  redirect_ready,
  output logic                  branch_ex,
  output logic                  jalr_ex,
  output logic                  branch_taken_ex,
  output logic                  is_loop_ex,
  output logic                  predict0_taken_ex,
  output logic                  predict1_taken_ex,
  output logic                  predict3_taken_ex,
  output logic [ADDR_WIDTH-1:0] branch_pc_ex,
  output logic [ADDR_WIDTH-1:0] branch_target_pc,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0] state;

  logic                  fd_valid;
  logic [ADDR_WIDTH-1:0] fd_pc;
  logic                  fd_pt;
  logic                  fd_p0;
  logic                  fd_p1;
  logic                  fd_p3;
  logic [ADDR_WIDTH-1:0] fd_ptgt;

  logic                  de_valid;
  logic [ADDR_WIDTH-1:0] de_pc;
  logic                  de_pt;
  logic                  de_p0;
  logic                  de_p1;
  logic                  de_p3;
  logic [ADDR_WIDTH-1:0] de_ptgt;
  logic                  de_branch;
  logic                  de_jalr;
  logic                  de_is_loop;
  logic [2:0]            de_funct3;
  logic [ADDR_WIDTH-1:0] de_imm;

  logic                  ex_live;
  logic                  legal_funct3;
  logic                  cond_true;
  logic                  update;
  logic                  actual_taken;
  logic                  mispredict;
  logic                  kill;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] jalr_target;
  logic [ADDR_WIDTH-1:0] actual_target;
  logic [ADDR_WIDTH-1:0] fall_through;

  // EX evaluation is suppressed while a redirect is outstanding.
  assign ex_live      = de_valid & (state == ST_IDLE);
  assign legal_funct3 = (de_funct3[2:1] != 2'b01);
  assign br_target    = de_pc + de_imm;
  assign jalr_sum     = src_data1_ex[ADDR_WIDTH-1:0] + de_imm;
  assign jalr_target  = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
  assign fall_through = de_pc + ADDR_WIDTH'(4);

  always_comb begin
    cond_true = 1'b0;
    case (de_funct3)
      3'b000:  cond_true = (src_data1_ex == src_data2_ex);
      3'b001:  cond_true = (src_data1_ex != src_data2_ex);
      3'b100:  cond_true = ($signed(src_data1_ex) <  $signed(src_data2_ex));
      3'b101:  cond_true = ($signed(src_data1_ex) >= $signed(src_data2_ex));
      3'b110:  cond_true = (src_data1_ex <  src_data2_ex);
      3'b111:  cond_true = (src_data1_ex >= src_data2_ex);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    branch_ex     = ex_live & de_branch & legal_funct3;
    jalr_ex       = ex_live & de_jalr;
    update        = branch_ex | jalr_ex;
    actual_taken  = de_jalr | cond_true;
    actual_target = de_jalr ? jalr_target : br_target;
    mispredict    = 1'b0;
    if (jalr_ex) begin
      mispredict = !(de_pt && (de_ptgt == actual_target));
    end else if (branch_ex) begin
      mispredict = (de_pt != actual_taken) ||
                   (de_pt && actual_taken && (de_ptgt != actual_target));
    end
    branch_taken_ex   = update & actual_taken;
    is_loop_ex        = update & de_is_loop;
    predict0_taken_ex = update & de_p0;
    predict1_taken_ex = update & de_p1;
    predict3_taken_ex = update & de_p3;
    branch_pc_ex      = update ? de_pc : '0;
    branch_target_pc  = update ? actual_target : '0;
  end

  assign flush          = mispredict;
  assign redirect_valid = (state == ST_REDIRECT);
  assign kill           = mispredict | (state == ST_REDIRECT);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mispredict) begin
            state       <= ST_REDIRECT;
            redirect_pc <= actual_taken ? actual_target : fall_through;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A kill (mispredict or pending redirect) wins over a DEC stall.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fd_valid <= 1'b0;
      fd_pc    <= '0;
      fd_pt    <= 1'b0;
      fd_p0    <= 1'b0;
      fd_p1    <= 1'b0;
      fd_p3    <= 1'b0;
      fd_ptgt  <= '0;
    end else if (kill) begin
      fd_valid <= 1'b0;
    end else if (!stall_dec) begin
      fd_valid <= if_valid;
      fd_pc    <= pc_if;
      fd_pt    <= predict_taken_if;
      fd_p0    <= predict0_taken_if;
      fd_p1    <= predict1_taken_if;
      fd_p3    <= predict3_taken_if;
      fd_ptgt  <= predict_target_pc_if;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      de_valid   <= 1'b0;
      de_pc      <= '0;
      de_pt      <= 1'b0;
      de_p0      <= 1'b0;
      de_p1      <= 1'b0;
      de_p3      <= 1'b0;
      de_ptgt    <= '0;
      de_branch  <= 1'b0;
      de_jalr    <= 1'b0;
      de_is_loop <= 1'b0;
      de_funct3  <= '0;
      de_imm     <= '0;
    end else begin
      de_valid <= fd_valid & ~stall_dec & ~kill;
      if (!kill && !stall_dec) begin
        de_pc      <= fd_pc;
        de_pt      <= fd_pt;
        de_p0      <= fd_p0;
        de_p1      <= fd_p1;
        de_p3      <= fd_p3;
        de_ptgt    <= fd_ptgt;
        de_branch  <= branch_dec;
        de_jalr    <= jalr_dec;
        de_is_loop <= is_loop_dec;
        de_funct3  <= funct3_dec;
        de_imm     <= imm_dec;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (update && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispredict && (mispredict_cnt_q != '1)) mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed test-plan cases plus random traffic checked
// against an instruction-level reference model.
module tb_branch_resolve;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        if_valid;
  logic [31:0] pc_if;
  logic        predict_taken_if, predict0_taken_if, predict1_taken_if, predict3_taken_if;
  logic [31:0] predict_target_pc_if;
  logic        stall_dec, branch_dec, jalr_dec, is_loop_dec;
  logic [2:0]  funct3_dec;
  logic [31:0] imm_dec, src_data1_ex, src_data2_ex;
  logic        redirect_ready;
  logic        branch_ex, jalr_ex, branch_taken_ex, is_loop_ex;
  logic        predict0_taken_ex, predict1_taken_ex, predict3_taken_ex;
  logic [31:0] branch_pc_ex, branch_target_pc;
  logic        redirect_valid, flush;
  logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

  branch_resolve #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .if_valid(if_valid), .pc_if(pc_if),
    .predict_taken_if(predict_taken_if), .predict0_taken_if(predict0_taken_if),
    .predict1_taken_if(predict1_taken_if), .predict3_taken_if(predict3_taken_if),
    .predict_target_pc_if(predict_target_pc_if), .stall_dec(stall_dec),
    .branch_dec(branch_dec), .jalr_dec(jalr_dec), .is_loop_dec(is_loop_dec),
    .funct3_dec(funct3_dec), .imm_dec(imm_dec), .src_data1_ex(src_data1_ex),
    .src_data2_ex(src_data2_ex), .redirect_ready(redirect_ready),
    .branch_ex(branch_ex), .jalr_ex(jalr_ex), .branch_taken_ex(branch_taken_ex),
    .is_loop_ex(is_loop_ex), .predict0_taken_ex(predict0_taken_ex),
    .predict1_taken_ex(predict1_taken_ex), .predict3_taken_ex(predict3_taken_ex),
    .branch_pc_ex(branch_pc_ex), .branch_target_pc(branch_target_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          pt, p0, p1, p3;
    logic [31:0] ptgt;
    bit          br, jalr, loop;
    logic [2:0]  f3;
    logic [31:0] imm, s1, s2;
  } instr_t;

  typedef struct {
    bit          bex, jex, taken, mis;
    logic [31:0] tgt;
  } res_t;

  instr_t      m_dec, m_ex, nop;
  bit          m_redirect;
  logic [31:0] m_rpc;
  logic [31:0] m_bcnt, m_mcnt;
  int          total = 0;
  int          bad = 0;
  bit          obs_rv, obs_flush, obs_bex, obs_jex, obs_taken;
  logic [31:0] obs_rpc, obs_tgt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                                input bit br, input bit jalr, input bit pt, input logic [31:0] ptgt,
                                input logic [31:0] s1, input logic [31:0] s2);
    instr_t r;
    r = '{default: '0};
    r.valid = 1'b1; r.pc = pc; r.imm = imm; r.f3 = f3; r.br = br; r.jalr = jalr;
    r.pt = pt; r.ptgt = ptgt; r.s1 = s1; r.s2 = s2;
    return r;
  endfunction

  function automatic instr_t randInstr();
    instr_t      r;
    logic [31:0] t;
    logic [31:0] tgt;
    int          kind;
    r = '{default: '0};
    t = $urandom;
    r.valid = ($urandom_range(0, 9) < 8);
    r.pc    = $urandom & 32'h000F_FFFC;
    r.imm   = {{20{t[11]}}, t[11:1], 1'b0};
    kind    = int'($urandom_range(0, 3));
    r.br    = (kind == 1) || (kind == 2);
    r.jalr  = (kind == 3);
    r.f3    = 3'($urandom_range(0, 7));
    r.loop  = 1'($urandom_range(0, 1));
    r.p0    = 1'($urandom_range(0, 1));
    r.p1    = 1'($urandom_range(0, 1));
    r.p3    = 1'($urandom_range(0, 1));
    r.pt    = 1'($urandom_range(0, 1));
    r.s1    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       r.s2 = r.s1;
      1:       r.s2 = r.s1 + 32'd1;
      2:       r.s2 = ~r.s1;
      default: r.s2 = $urandom;
    endcase
    tgt    = r.jalr ? ((r.s1 + r.imm) & 32'hFFFF_FFFE) : (r.pc + r.imm);
    r.ptgt = ($urandom_range(0, 3) != 0) ? tgt : ($urandom & 32'hFFFF_FFFE);
    return r;
  endfunction

  // Architectural outcome of one instruction sitting in EX.
  function automatic res_t resolve(input instr_t i, input bit redirect);
    res_t r;
    r = '{default: '0};
    if (!i.valid || redirect) return r;
    if (i.jalr) begin
      r.jex   = 1'b1;
      r.taken = 1'b1;
      r.tgt   = (i.s1 + i.imm) & 32'hFFFF_FFFE;
      r.mis   = !(i.pt && (i.ptgt == r.tgt));
    end else if (i.br && i.f3 != 3'd2 && i.f3 != 3'd3) begin
      r.bex = 1'b1;
      case (i.f3)
        3'd0:    r.taken = (i.s1 == i.s2);
        3'd1:    r.taken = (i.s1 != i.s2);
        3'd4:    r.taken = (int'(i.s1) < int'(i.s2));
        3'd5:    r.taken = (int'(i.s1) >= int'(i.s2));
        3'd6:    r.taken = (i.s1 < i.s2);
        default: r.taken = (i.s1 >= i.s2);
      endcase
      r.tgt = i.pc + i.imm;
      r.mis = (i.pt != r.taken) || (i.pt && r.taken && (i.ptgt != r.tgt));
    end
    return r;
  endfunction

  task automatic resetModel();
    m_dec = nop; m_ex = nop; m_redirect = 1'b0; m_rpc = '0; m_bcnt = '0; m_mcnt = '0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_bex"},  32'(branch_ex), 32'd0);
    checkOutput({tag, "_jex"},  32'(jalr_ex), 32'd0);
    checkOutput({tag, "_tkn"},  32'(branch_taken_ex), 32'd0);
    checkOutput({tag, "_loop"}, 32'(is_loop_ex), 32'd0);
    checkOutput({tag, "_p013"}, 32'({predict0_taken_ex, predict1_taken_ex, predict3_taken_ex}), 32'd0);
    checkOutput({tag, "_bpc"},  branch_pc_ex, 32'd0);
    checkOutput({tag, "_tgt"},  branch_target_pc, 32'd0);
    checkOutput({tag, "_rv"},   32'(redirect_valid), 32'd0);
    checkOutput({tag, "_rpc"},  redirect_pc, 32'd0);
    checkOutput({tag, "_fl"},   32'(flush), 32'd0);
    checkOutput({tag, "_bcnt"}, branch_cnt, 32'd0);
    checkOutput({tag, "_mcnt"}, mispredict_cnt, 32'd0);
  endtask

  // One cycle: drive IF with nxt, DEC/EX inputs from the model, check, then advance the model.
  task automatic applyStimulus(input instr_t nxt, input bit stall, input bit ready);
    res_t r;
    bit   upd;
    @(negedge cpu_clk);
    if_valid = nxt.valid; pc_if = nxt.pc; predict_taken_if = nxt.pt;
    predict0_taken_if = nxt.p0; predict1_taken_if = nxt.p1; predict3_taken_if = nxt.p3;
    predict_target_pc_if = nxt.ptgt;
    stall_dec = stall; branch_dec = m_dec.br; jalr_dec = m_dec.jalr; is_loop_dec = m_dec.loop;
    funct3_dec = m_dec.f3; imm_dec = m_dec.imm;
    src_data1_ex = m_ex.s1; src_data2_ex = m_ex.s2;
    redirect_ready = ready;
    #1;
    r   = resolve(m_ex, m_redirect);
    upd = r.bex | r.jex;
    checkOutput("branch_ex", 32'(branch_ex), 32'(r.bex));
    checkOutput("jalr_ex", 32'(jalr_ex), 32'(r.jex));
    checkOutput("taken", 32'(branch_taken_ex), 32'(upd & r.taken));
    checkOutput("is_loop", 32'(is_loop_ex), 32'(upd & m_ex.loop));
    checkOutput("pred013", 32'({predict0_taken_ex, predict1_taken_ex, predict3_taken_ex}),
                32'({upd & m_ex.p0, upd & m_ex.p1, upd & m_ex.p3}));
    checkOutput("branch_pc", branch_pc_ex, upd ? m_ex.pc : 32'd0);
    checkOutput("target_pc", branch_target_pc, upd ? r.tgt : 32'd0);
    checkOutput("flush", 32'(flush), 32'(r.mis));
    checkOutput("redirect_valid", 32'(redirect_valid), 32'(m_redirect));
    if (m_redirect) checkOutput("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_PERF_CNT_EN
    checkOutput("branch_cnt", branch_cnt, m_bcnt);
    checkOutput("mispredict_cnt", mispredict_cnt, m_mcnt);
`else
    checkOutput("branch_cnt", branch_cnt, 32'd0);
    checkOutput("mispredict_cnt", mispredict_cnt, 32'd0);
`endif
    obs_rv = redirect_valid; obs_rpc = redirect_pc; obs_flush = flush;
    obs_bex = branch_ex; obs_jex = jalr_ex; obs_taken = branch_taken_ex; obs_tgt = branch_target_pc;

    if (upd && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
    if (r.mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
    if (m_redirect) begin
      if (ready) m_redirect = 1'b0;
      m_dec = nop; m_ex = nop;
    end else if (r.mis) begin
      m_redirect = 1'b1;
      m_rpc = r.taken ? r.tgt : (m_ex.pc + 32'd4);
      m_dec = nop; m_ex = nop;
    end else if (stall) begin
      m_ex = nop;
    end else begin
      m_ex = m_dec;
      m_dec = nxt;
    end
  endtask

  task automatic runToEx(input instr_t i);
    applyStimulus(i, 1'b0, 1'b0);
    applyStimulus(nop, 1'b0, 1'b0);
    applyStimulus(nop, 1'b0, 1'b0);
  endtask

  initial begin
    instr_t a, b;
    nop = '{default: '0};
    cpu_rst = 1'b1;
    if_valid = 1'b0; pc_if = '0; predict_taken_if = 1'b0; predict0_taken_if = 1'b0;
    predict1_taken_if = 1'b0; predict3_taken_if = 1'b0; predict_target_pc_if = '0;
    stall_dec = 1'b0; branch_dec = 1'b0; jalr_dec = 1'b0; is_loop_dec = 1'b0;
    funct3_dec = '0; imm_dec = '0; src_data1_ex = '0; src_data2_ex = '0; redirect_ready = 1'b0;
    resetModel();
    repeat (2) @(negedge cpu_clk);
    #1 checkIdleOutputs("reset");
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Correctly predicted taken BEQ.
    runToEx(mk(32'h100, 32'h20, 3'd0, 1'b1, 1'b0, 1'b1, 32'h120, 32'd5, 32'd5));
    checkOutput("beq_bex", 32'(obs_bex), 32'd1);
    checkOutput("beq_taken", 32'(obs_taken), 32'd1);
    checkOutput("beq_tgt", obs_tgt, 32'h120);
    checkOutput("beq_flush", 32'(obs_flush), 32'd0);
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("beq_rv", 32'(obs_rv), 32'd0);

    // Signed BLT predicted not-taken but taken.
    runToEx(mk(32'h200, 32'h40, 3'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1));
    checkOutput("blt_flush", 32'(obs_flush), 32'd1);
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("blt_rv", 32'(obs_rv), 32'd1);
    checkOutput("blt_rpc", obs_rpc, 32'h240);
`ifdef BRANCH_PERF_CNT_EN
    checkOutput("blt_mcnt", mispredict_cnt, 32'd1);
`endif
    applyStimulus(nop, 1'b0, 1'b1);

    // BNE not taken but predicted taken; redirect held for 4 cycles.
    runToEx(mk(32'h300, 32'h40, 3'd1, 1'b1, 1'b0, 1'b1, 32'h340, 32'd7, 32'd7));
    checkOutput("bne_flush", 32'(obs_flush), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(nop, 1'b0, (k == 3));
      checkOutput("bne_rv", 32'(obs_rv), 32'd1);
      checkOutput("bne_rpc", obs_rpc, 32'h304);
    end
    applyStimulus(nop, 1'b0, 1'b1);
    checkOutput("bne_idle", 32'(obs_rv), 32'd0);

    // JALR: low bit cleared from the target.
    runToEx(mk(32'h400, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h1001, 32'd0));
    checkOutput("jalr_ok_jex", 32'(obs_jex), 32'd1);
    checkOutput("jalr_ok_flush", 32'(obs_flush), 32'd0);
    runToEx(mk(32'h400, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h1001, 32'd0));
    checkOutput("jalr_bad_flush", 32'(obs_flush), 32'd1);
    applyStimulus(nop, 1'b0, 1'b1);
    checkOutput("jalr_rpc", obs_rpc, 32'h1000);

    // Mispredict in EX while DEC is stalled: the DEC instruction is killed.
    a = mk(32'h200, 32'h40, 3'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1);
    b = mk(32'h600, 32'h8, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'd0);
    applyStimulus(a, 1'b0, 1'b0);
    applyStimulus(b, 1'b0, 1'b0);
    applyStimulus(nop, 1'b1, 1'b0);
    checkOutput("stall_flush", 32'(obs_flush), 32'd1);
    applyStimulus(nop, 1'b0, 1'b1);
    checkOutput("stall_rv", 32'(obs_rv), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(nop, 1'b0, 1'b0);
      checkOutput("stall_killed", 32'(obs_jex), 32'd0);
    end

    for (int c = 0; c < 3000; c++)
      applyStimulus(randInstr(), ($urandom_range(0, 99) < 15), 1'($urandom_range(0, 1)));

    // Reset arriving mid-redirect.
    runToEx(mk(32'h200, 32'h40, 3'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1));
    applyStimulus(nop, 1'b0, 1'b0);
    checkOutput("pre_rst_rv", 32'(obs_rv), 32'd1);
    @(negedge cpu_clk);
    #2 cpu_rst = 1'b1;
    #1 checkOutput("rst_rv_drop", 32'(redirect_valid), 32'd0);
    checkIdleOutputs("midrst");
    resetModel();
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1 checkIdleOutputs("postrst");
    applyStimulus(nop, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

EX-stage branch resolution unit. It carries each fetched instruction's prediction bits from IF through DEC into EX and evaluates conditional branches and JALR against their real operands. It generates the predictor update bus (`branch_ex`, `branch_taken_ex`, `branch_pc_ex`, `branch_target_pc`, `predict*_taken_ex`, `is_loop_ex`, `jalr_ex`) and raises a fetch redirect with pipeline flush on every mispredict. It sits between the IF-stage branch predictor (producer of the prediction bits and consumer of the update bus) and the fetch PC generator (consumer of the redirect).

## Interface
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, operand width.
- CNT_WIDTH, 32, performance counter width.

Ports (clock and reset first):
- cpu_clk  in  1  core clock.
- cpu_rst  in  1  reset; **asynchronous, active-high**. This is the decided clocking/reset scheme: one clock, async active-high reset.
- if_valid  in  1  the IF instruction is valid.
- pc_if  in  ADDR_WIDTH  PC of the IF instruction.
- predict_taken_if, predict0_taken_if, predict1_taken_if, predict3_taken_if  in  1 each  predictor outputs for the IF instruction.
- predict_target_pc_if  in  ADDR_WIDTH  predicted target.
- stall_dec  in  1  hazard stall in DEC.
- branch_dec, jalr_dec, is_loop_dec  in  1 each  decode flags.
- funct3_dec  in  3  branch condition.
- imm_dec  in  ADDR_WIDTH  sign-extended immediate.
- src_data1_ex, src_data2_ex  in  DATA_WIDTH  forwarded EX operands.
- redirect_ready  in  1  fetch accepts the redirect.
- branch_ex, jalr_ex, branch_taken_ex, is_loop_ex  out  1 each  predictor update bus.
- predict0_taken_ex, predict1_taken_ex, predict3_taken_ex  out  1 each  update bus.
- branch_pc_ex, branch_target_pc  out  ADDR_WIDTH  update bus.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  ADDR_WIDTH  redirect target.
- flush  out  1  kill IF/DEC instructions.
- branch_cnt, mispredict_cnt  out  CNT_WIDTH each  performance counters.

## Operation
- Pipeline registers:
  - IF/DEC register: {valid, pc, predict bits, predicted target}.
  - DEC/EX register: the IF/DEC contents plus {branch, jalr, is_loop, funct3, imm}.
- Stall: when stall_dec=1, the IF/DEC register holds and a bubble (valid=0) enters DEC/EX.
- Condition evaluation on src1/src2 by funct3:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 and 011 are not branches: branch_ex=0 and no mispredict is raised.
- Targets (all modulo 2^ADDR_WIDTH):
  - Conditional branch: target = pc+imm.
  - JALR: target = (src1+imm) & ~1.
  - Fall-through address: pc+4.
- Update bus:
  - branch_ex = EX valid & branch & legal funct3.
  - jalr_ex = EX valid & jalr.
  - The remaining update fields are valid only when branch_ex or jalr_ex is high; they are 0 otherwise.
- Mispredict for a conditional branch, either of:
  - predict_taken != actual taken;
  - predicted and actual both taken, but predicted target != target.
- Mispredict for JALR: !(predict_taken & predicted target == target).
- Redirect address: actual taken ? target : pc+4. JALR is always taken.
- FSM states: IDLE, REDIRECT.
  - IDLE -> REDIRECT on a mispredict.
  - REDIRECT -> IDLE when redirect_valid & redirect_ready.
- REDIRECT behaviour:
  - redirect_valid=1, holding a stable redirect_pc.
  - Both pipeline registers load valid=0 and if_valid is ignored.
  - No EX evaluation happens, so a second mispredict cannot occur.
- Flush priority: flush overrides stall_dec.

## Timing
- Reset values: every output is 0, the FSM is IDLE, and all valid bits are 0.
- Pipeline latency: an instruction presented in IF at cycle N (no stall) reaches EX in cycle N+2.
- The update bus is combinational from EX state in that cycle, so the predictor writes on the closing edge.
- Mispredict detected in EX at cycle N:
  - flush=1 in cycle N (combinational).
  - redirect_valid=1 from cycle N+1, registered.
  - The pipeline is empty from cycle N+1.
- Redirect handshake:
  - redirect_valid stays high until redirect_ready is sampled high.
  - redirect_pc is constant while redirect_valid=1.
  - redirect_ready=1 in the first REDIRECT cycle gives a one-cycle pulse; IDLE resumes in N+2.
  - redirect_ready while in IDLE is ignored.
- Reset asserted mid-REDIRECT: the FSM returns to IDLE asynchronously and redirect_valid drops immediately.

## Configuration
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - branch_cnt increments per cycle with branch_ex|jalr_ex.
  - mispredict_cnt increments per mispredict.
  - Both saturate at all-ones and reset to 0.
- Undefined: no counter flops are built and both outputs are tied to 0.

## Test plan
- BEQ at pc 0x100, imm 0x20, src1=src2=5, predicted taken to 0x120 -> branch_ex=1, branch_taken_ex=1, branch_target_pc=0x120, no flush, redirect_valid stays 0.
- BLT with src1=0xFFFFFFFF, src2=1, predicted not taken, pc 0x200, imm 0x40 -> flush=1 in the EX cycle; redirect_valid=1 with redirect_pc=0x240 the next cycle; mispredict_cnt=1.
- BNE with equal operands, predicted taken, pc 0x300 -> redirect_pc=0x304; hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stay stable for 4 cycles, then IDLE.
- JALR with src1=0x1001, imm=0, predicted target 0x1000 taken -> no redirect; with predicted target 0x2000 -> redirect_pc=0x1000.
- stall_dec=1 in the same cycle an EX mispredict occurs -> both stages invalid next cycle, and the IF/DEC instruction never reaches EX.
- Assert cpu_rst during REDIRECT -> redirect_valid=0 immediately; all outputs and counters are 0 after release (with BRANCH_PERF_CNT_EN defined).
